oscillating_fsm_decoder: RTL

OSCILLATING_FSM_DECODER -- requirements
Module: oscillating_fsm_decoder

---
 rtl/osc_fsm_pkg.sv | 26 ++
 rtl/osc_sat_cnt.sv | 22 ++
 rtl/oscillating_fsm_decoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/osc_fsm_pkg.sv
// Shared encodings for the oscillating FSM decoder: state codes, transition
// deltas and the decoder state enum.
package osc_fsm_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam logic [1:0] DELTA_NONE   = 2'b00;
    localparam logic [1:0] DELTA_STAY   = 2'b01;
    localparam logic [1:0] DELTA_SWITCH = 2'b10;
    localparam logic [1:0] DELTA_BOTH   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACQ  = 2'b01,
        LOCK = 2'b10
    } dec_state_e;

    // Exactly one bit must toggle between consecutive encoder states.
    function automatic logic is_legal(input logic [1:0] delta);
        return (delta == DELTA_STAY) || (delta == DELTA_SWITCH);
    endfunction

endpackage

// File: rtl/osc_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module osc_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/oscillating_fsm_decoder.sv
// Recovers control bit A from an oscillating 2-bit FSM encoding and tracks lock.
// Optional switch counter output enabled by defining OSC_DEC_SWITCH_CNT_EN.
module oscillating_fsm_decoder
    import osc_fsm_pkg::*;
#(
    parameter int LOCK_N = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] state_in,
    input  logic       state_vld,
    output logic       a_out,
    output logic       a_vld,
    output logic       err,
    output logic       locked,
    output logic [7:0] err_cnt
`ifdef OSC_DEC_SWITCH_CNT_EN
    ,
    output logic [7:0] switch_cnt
`endif
);

    localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);

    dec_state_e state;
    logic [1:0] prev;
    logic [3:0] run_cnt;

    logic [1:0] delta;
    logic       legal;
    logic       active;
    logic       err_ev;
    logic [3:0] next_run;

    assign delta    = prev ^ state_in;
    assign legal    = is_legal(delta);
    assign active   = state_vld && (state != IDLE);
    assign err_ev   = active && !legal;
    assign next_run = (run_cnt == LOCK_N_C) ? run_cnt : run_cnt + 4'd1;

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            prev    <= S0;
            run_cnt <= '0;
            a_out   <= 1'b0;
            a_vld   <= 1'b0;
            err     <= 1'b0;
            locked  <= 1'b0;
        end else begin
            a_vld <= 1'b0;
            err   <= 1'b0;
            if (state_vld) begin
                case (state)
                    IDLE: begin
                        prev    <= state_in;
                        run_cnt <= '0;
                        state   <= ACQ;
                        locked  <= 1'b0;
                    end
                    ACQ, LOCK: begin
                        prev <= state_in;
                        if (legal) begin
                            a_out   <= (delta == DELTA_SWITCH);
                            a_vld   <= 1'b1;
                            run_cnt <= next_run;
                            if (next_run == LOCK_N_C) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            err     <= 1'b1;
                            run_cnt <= '0;
                            state   <= ACQ;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    osc_sat_cnt #(.WIDTH(8)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (err_ev),
        .count   (err_cnt)
    );

`ifdef OSC_DEC_SWITCH_CNT_EN
    logic sw_ev;
    assign sw_ev = active && (delta == DELTA_SWITCH);

    osc_sat_cnt #(.WIDTH(8)) u_switch_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (sw_ev),
        .count   (switch_cnt)
    );
`endif

endmodule
